// File: rtl/ctrl_pkg.sv
// Shared control-bundle layout for the main decoder and the pipeline control registers.
package ctrl_pkg;

  localparam int unsigned WB_W = 2;
  localparam int unsigned M_W  = 3;
  localparam int unsigned EX_W = 4;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam int unsigned M_BRANCH   = 2;
  localparam int unsigned M_MEMREAD  = 1;
  localparam int unsigned M_MEMWRITE = 0;

  localparam int unsigned EX_REGDST   = 3;
  localparam int unsigned EX_ALUOP_HI = 2;
  localparam int unsigned EX_ALUOP_LO = 1;
  localparam int unsigned EX_ALUSRC   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_regs_if.sv
// Decoder-side inputs and per-stage control outputs of the pipeline control registers.
interface ctrl_pipe_regs_if #(
  parameter int unsigned REG_AW = 5
);
  import ctrl_pkg::*;

  logic [WB_W-1:0]   id_wb;
  logic [M_W-1:0]    id_m;
  logic [EX_W-1:0]   id_ex;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              ex_zero;

  logic              ex_regdst;
  logic              ex_alusrc;
  logic [1:0]        ex_aluop;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              mem_branch;
  logic              mem_memread;
  logic              mem_memwrite;
  logic              wb_regwrite;
  logic              wb_memtoreg;
  logic [REG_AW-1:0] wb_dest;
  logic              branch_taken;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;

  modport master (
    output id_wb, id_m, id_ex, id_rs, id_rt, id_rd, ex_zero,
    input  ex_regdst, ex_alusrc, ex_aluop, ex_rs, ex_rt,
    input  mem_branch, mem_memread, mem_memwrite,
    input  wb_regwrite, wb_memtoreg, wb_dest,
    input  branch_taken, pc_write, ifid_write, ifid_flush
  );

  modport slave (
    input  id_wb, id_m, id_ex, id_rs, id_rt, id_rd, ex_zero,
    output ex_regdst, ex_alusrc, ex_aluop, ex_rs, ex_rt,
    output mem_branch, mem_memread, mem_memwrite,
    output wb_regwrite, wb_memtoreg, wb_dest,
    output branch_taken, pc_write, ifid_write, ifid_flush
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX targets a source of the instruction in ID.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              stall
);

  // Register 0 is hardwired, so a load into it never creates a dependency.
  always_comb begin
    stall = idex_memread && (idex_rt != '0) && ((idex_rt == id_rs) || (idex_rt == id_rt));
  end

endmodule

// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall and MEM-stage branch flush.
module ctrl_pipe_regs
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input logic             clk,
  input logic             rst,
  ctrl_pipe_regs_if.slave bus
);

  ctrl_bundle_t      idex_ctrl_q, idex_ctrl_d;
  logic [REG_AW-1:0] idex_rs_q, idex_rs_d;
  logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
  logic [REG_AW-1:0] idex_rd_q, idex_rd_d;

  logic [WB_W-1:0]   exmem_wb_q, exmem_wb_d;
  logic [M_W-1:0]    exmem_m_q, exmem_m_d;
  logic [REG_AW-1:0] exmem_dest_q, exmem_dest_d;
  logic              exmem_zero_q, exmem_zero_d;

  logic [WB_W-1:0]   memwb_wb_q, memwb_wb_d;
  logic [REG_AW-1:0] memwb_dest_q, memwb_dest_d;

  logic stall;
  logic taken;
  logic stall_eff;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .idex_memread (idex_ctrl_q.m[M_MEMREAD]),
    .idex_rt      (idex_rt_q),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .stall        (stall)
  );

  assign taken     = exmem_m_q[M_BRANCH] & exmem_zero_q;
  // A taken branch squashes the dependent instruction anyway, so it overrides the stall.
  assign stall_eff = stall & ~taken;

  always_comb begin
    idex_ctrl_d = {bus.id_wb, bus.id_m, bus.id_ex};
    if (taken || stall) begin
      idex_ctrl_d = CTRL_NOP;
    end
    idex_rs_d = bus.id_rs;
    idex_rt_d = bus.id_rt;
    idex_rd_d = bus.id_rd;

    exmem_wb_d   = idex_ctrl_q.wb;
    exmem_m_d    = idex_ctrl_q.m;
    if (taken) begin
      exmem_wb_d = '0;
      exmem_m_d  = '0;
    end
    exmem_dest_d = idex_ctrl_q.ex[EX_REGDST] ? idex_rd_q : idex_rt_q;
    exmem_zero_d = bus.ex_zero;

    memwb_wb_d   = exmem_wb_q;
    memwb_dest_d = exmem_dest_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ctrl_q  <= CTRL_NOP;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      exmem_wb_q   <= '0;
      exmem_m_q    <= '0;
      exmem_dest_q <= '0;
      exmem_zero_q <= 1'b0;
      memwb_wb_q   <= '0;
      memwb_dest_q <= '0;
    end else begin
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      exmem_wb_q   <= exmem_wb_d;
      exmem_m_q    <= exmem_m_d;
      exmem_dest_q <= exmem_dest_d;
      exmem_zero_q <= exmem_zero_d;
      memwb_wb_q   <= memwb_wb_d;
      memwb_dest_q <= memwb_dest_d;
    end
  end

  always_comb begin
    bus.ex_regdst    = idex_ctrl_q.ex[EX_REGDST];
    bus.ex_aluop     = idex_ctrl_q.ex[EX_ALUOP_HI:EX_ALUOP_LO];
    bus.ex_alusrc    = idex_ctrl_q.ex[EX_ALUSRC];
    bus.ex_rs        = idex_rs_q;
    bus.ex_rt        = idex_rt_q;
    bus.mem_branch   = exmem_m_q[M_BRANCH];
    bus.mem_memread  = exmem_m_q[M_MEMREAD];
    bus.mem_memwrite = exmem_m_q[M_MEMWRITE];
    bus.wb_regwrite  = memwb_wb_q[WB_REGWRITE];
    bus.wb_memtoreg  = memwb_wb_q[WB_MEMTOREG];
    bus.wb_dest      = memwb_dest_q;
    bus.branch_taken = taken;
    bus.ifid_flush   = taken;
    bus.pc_write     = ~stall_eff;
    bus.ifid_write   = ~stall_eff;
  end

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed vector table, reset sequence and randomized run against an instruction-slot model.
module tb_ctrl_pipe_regs;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ctrl_pipe_regs_if #(.REG_AW(5)) bus ();

  ctrl_pipe_regs #(.REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
    logic [4:0] rs, rt, rd;
    logic       zero;
    logic       pcw;
    logic       bt;
    logic [3:0] exo;
    logic [2:0] memo;
    logic [1:0] wbo;
    logic [4:0] dest;
  } vec_t;

  vec_t vecs[$];

  // One in-flight instruction as seen by the model; spec_ok=0 marks squashed specifiers.
  typedef struct {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
    logic [4:0] rs, rt, rd, dest;
    logic       zero;
    bit         spec_ok;
  } slot_t;

  slot_t s_ex, s_mem, s_wb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic zero, input logic pcw, input logic bt,
                         input logic [3:0] exo, input logic [2:0] memo, input logic [1:0] wbo,
                         input logic [4:0] dest);
    vec_t v;
    v.wb = wb; v.m = m; v.ex = ex; v.rs = rs; v.rt = rt; v.rd = rd; v.zero = zero;
    v.pcw = pcw; v.bt = bt; v.exo = exo; v.memo = memo; v.wbo = wbo; v.dest = dest;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic zero);
    bus.id_wb = wb; bus.id_m = m; bus.id_ex = ex;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.ex_zero = zero;
  endtask

  function automatic logic [3:0] ex_out();
    return {bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc};
  endfunction

  function automatic logic [2:0] mem_out();
    return {bus.mem_branch, bus.mem_memread, bus.mem_memwrite};
  endfunction

  function automatic logic [1:0] wb_out();
    return {bus.wb_regwrite, bus.wb_memtoreg};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " ex"}, ex_out(), 4'b0000);
    check({tag, " mem"}, mem_out(), 3'b000);
    check({tag, " wb"}, wb_out(), 2'b00);
    check({tag, " wb_dest"}, bus.wb_dest, 5'd0);
    check({tag, " ex_rs/rt"}, {bus.ex_rs, bus.ex_rt}, 10'd0);
    check({tag, " bt/flush"}, {bus.branch_taken, bus.ifid_flush}, 2'b00);
    check({tag, " pcw/ifw"}, {bus.pc_write, bus.ifid_write}, 2'b11);
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.wb = '0; s.m = '0; s.ex = '0; s.rs = '0; s.rt = '0; s.rd = '0; s.dest = '0;
    s.zero = 1'b0; s.spec_ok = 1'b1;
    return s;
  endfunction

  initial begin
    rst = 1'b1;
    drive(2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");

    // wb m ex rs rt rd zero | pcw bt ex mem wb dest (dest checked only when regwrite expected)
    add_vec(2'b10, 3'b000, 4'b1100, 1, 7, 3, 0,  1, 0, 4'b0000, 3'b000, 2'b00, 0);
    add_vec(2'b11, 3'b010, 4'b0001, 2, 5, 0, 0,  1, 0, 4'b1100, 3'b000, 2'b00, 0);
    add_vec(2'b10, 3'b000, 4'b1100, 5, 6, 8, 0,  0, 0, 4'b0001, 3'b000, 2'b00, 0);
    add_vec(2'b10, 3'b000, 4'b1100, 5, 6, 8, 0,  1, 0, 4'b0000, 3'b010, 2'b10, 3);
    add_vec(2'b00, 3'b100, 4'b0010, 1, 2, 0, 0,  1, 0, 4'b1100, 3'b000, 2'b11, 5);
    add_vec(2'b10, 3'b000, 4'b1100, 3, 4, 9, 1,  1, 0, 4'b0010, 3'b000, 2'b00, 0);
    add_vec(2'b11, 3'b010, 4'b0001, 1, 3, 0, 0,  1, 1, 4'b1100, 3'b100, 2'b10, 8);
    add_vec(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0,  1, 0, 4'b0000, 3'b000, 2'b00, 0);
    add_vec(2'b00, 3'b100, 4'b0010, 1, 1, 0, 0,  1, 0, 4'b0000, 3'b000, 2'b00, 0);
    add_vec(2'b11, 3'b010, 4'b0001, 0, 4, 0, 1,  1, 0, 4'b0010, 3'b000, 2'b00, 0);
    add_vec(2'b10, 3'b000, 4'b1100, 4, 0, 5, 0,  1, 1, 4'b0001, 3'b100, 2'b00, 0);
    add_vec(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0,  1, 0, 4'b0000, 3'b000, 2'b00, 0);
    add_vec(2'b11, 3'b010, 4'b0001, 0, 0, 0, 0,  1, 0, 4'b0000, 3'b000, 2'b00, 0);
    add_vec(2'b10, 3'b000, 4'b1100, 0, 0, 5, 0,  1, 0, 4'b0001, 3'b000, 2'b00, 0);
    add_vec(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0,  1, 0, 4'b1100, 3'b010, 2'b00, 0);
    add_vec(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0,  1, 0, 4'b0000, 3'b000, 2'b11, 0);
    add_vec(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0,  1, 0, 4'b0000, 3'b000, 2'b10, 5);
    add_vec(2'b00, 3'b100, 4'b0010, 0, 1, 0, 0,  1, 0, 4'b0000, 3'b000, 2'b00, 0);
    add_vec(2'b10, 3'b000, 4'b1100, 0, 2, 9, 0,  1, 0, 4'b0010, 3'b000, 2'b00, 0);
    add_vec(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0,  1, 0, 4'b1100, 3'b100, 2'b00, 0);
    add_vec(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0,  1, 0, 4'b0000, 3'b000, 2'b00, 0);
    add_vec(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0,  1, 0, 4'b0000, 3'b000, 2'b10, 9);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wb, vecs[i].m, vecs[i].ex, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].zero);
      #1;
      check($sformatf("vec%0d pcw/ifw", i), {bus.pc_write, bus.ifid_write}, {2{vecs[i].pcw}});
      check($sformatf("vec%0d bt/flush", i), {bus.branch_taken, bus.ifid_flush},
            {2{vecs[i].bt}});
      check($sformatf("vec%0d ex", i), ex_out(), vecs[i].exo);
      check($sformatf("vec%0d mem", i), mem_out(), vecs[i].memo);
      check($sformatf("vec%0d wb", i), wb_out(), vecs[i].wbo);
      if (vecs[i].wbo[1]) check($sformatf("vec%0d wb_dest", i), bus.wb_dest, vecs[i].dest);
      @(negedge clk);
    end

    // Reset with an R-type in MEM and a store in EX: neither may issue afterwards.
    drive(2'b10, 3'b000, 4'b1100, 1, 2, 4, 0);
    @(negedge clk);
    drive(2'b00, 3'b001, 4'b0001, 1, 2, 0, 0);
    @(negedge clk);
    drive(2'b00, 3'b000, 4'b0000, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("pre-reset ex sw", ex_out(), 4'b0001);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset memwrite", bus.mem_memwrite, 1'b0);
    check_reset_outputs("post-reset");

    // Randomized run against the slot model; the first cycle is a reset to align states.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       r;
      logic       taken_e, hz_e, stall_e;
      logic [1:0] wb;
      logic [2:0] m;
      logic [3:0] ex;
      logic [4:0] rs, rt, rd;
      logic       z;
      slot_t      nxt;
      @(negedge clk);
      r  = (cyc == 0) || ($urandom_range(0, 39) == 0);
      wb = 2'($urandom);
      m  = 3'($urandom);
      ex = 4'($urandom);
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      z  = 1'($urandom);
      rst = r;
      drive(wb, m, ex, rs, rt, rd, z);
      #1;
      taken_e = s_mem.m[2] && s_mem.zero;
      hz_e    = s_ex.m[1] && (s_ex.rt != 0) && (s_ex.rt == rs || s_ex.rt == rt);
      stall_e = hz_e && !taken_e;
      if (cyc > 0) begin
        check($sformatf("rnd%0d pcw/ifw", cyc), {bus.pc_write, bus.ifid_write}, {2{!stall_e}});
        check($sformatf("rnd%0d bt/flush", cyc), {bus.branch_taken, bus.ifid_flush},
              {2{taken_e}});
        check($sformatf("rnd%0d ex", cyc), ex_out(), s_ex.ex);
        check($sformatf("rnd%0d mem", cyc), mem_out(), s_mem.m);
        check($sformatf("rnd%0d wb", cyc), wb_out(), s_wb.wb);
        if (s_ex.spec_ok) check($sformatf("rnd%0d ex_rs/rt", cyc), {bus.ex_rs, bus.ex_rt},
                                {s_ex.rs, s_ex.rt});
        if (s_wb.spec_ok) check($sformatf("rnd%0d wb_dest", cyc), bus.wb_dest, s_wb.dest);
      end
      @(posedge clk);
      if (r) begin
        s_ex = empty_slot(); s_mem = empty_slot(); s_wb = empty_slot();
      end else begin
        s_wb = s_mem;
        if (taken_e) begin
          s_mem = empty_slot();
          s_mem.spec_ok = 1'b0;
        end else begin
          s_mem      = s_ex;
          s_mem.zero = z;
          s_mem.dest = s_ex.ex[3] ? s_ex.rd : s_ex.rt;
        end
        nxt.wb = wb; nxt.m = m; nxt.ex = ex; nxt.rs = rs; nxt.rt = rt; nxt.rd = rd;
        nxt.dest = '0; nxt.zero = 1'b0; nxt.spec_ok = 1'b1;
        if (taken_e || hz_e) begin
          nxt.wb = '0; nxt.m = '0; nxt.ex = '0;
          nxt.spec_ok = !taken_e;
        end
        s_ex = nxt;
      end
    end

    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
